// File: rtl/sm_display_pkg.sv
// Shared definitions for the hex display block: active-low segment codes and width helpers.
// Used by sm_hex_to_seg and sm_hex_display.
package sm_display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} code for each nibble value 0..F.
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // A single-digit display still needs a one-bit index register.
  function automatic int idx_w(input int digits);
    return (clog2(digits) < 1) ? 1 : clog2(digits);
  endfunction

endpackage

// File: rtl/sm_hex_to_seg.sv
// Combinational nibble to active-low 7-segment decoder.
module sm_hex_to_seg
  import sm_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_CODES[nibble];

endmodule

// File: rtl/sm_hex_display.sv
// Multiplexed hex display scanner with a once-per-frame snapshot and freeze control.
// Optional leading-zero blanking is enabled by defining SM_DISPLAY_BLANK_EN.
module sm_hex_display
  import sm_display_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       value,
  input  logic              freeze,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              frame_start
);

  localparam int IDX_W = idx_w(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [SCAN_DIV_W-1:0] pre;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           snap;

  logic                  tick;
  logic                  load;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic                  digit_on;
  logic [DIGITS-1:0]     an_next;

  assign tick   = &pre;
  assign load   = tick && (idx == LAST_IDX);
  assign nibble = 4'(snap >> {idx, 2'b00});

  sm_hex_to_seg u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef SM_DISPLAY_BLANK_EN
  // Highest displayed digit holding a non-zero nibble; digit 0 is always shown.
  function automatic int top_digit(input logic [31:0] s);
    int top;
    top = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] != 4'h0) top = k;
    end
    return top;
  endfunction

  assign digit_on = (int'(idx) <= top_digit(snap));
`else
  assign digit_on = 1'b1;
`endif

  assign an_next = digit_on ? ~(DIGITS'(1) << idx) : '1;

  // Outputs are registered from the current idx/snap, so they trail idx by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre         <= '0;
      idx         <= '0;
      snap        <= '0;
      frame_start <= 1'b0;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else begin
      pre         <= pre + 1'b1;
      frame_start <= load;
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if (load && !freeze) begin
        snap <= value;
      end
      an  <= an_next;
      seg <= dec_seg;
      dp  <= !((idx == '0) && freeze);
    end
  end

endmodule

// File: tb/tb_sm_hex_display.sv
// Bench for sm_hex_display: an 8-digit and a 4-digit instance checked against a time-based model.
module tb_sm_hex_display;

  localparam int SDW = 2;
  localparam int P   = 1 << SDW;
  localparam int DIG [2] = '{8, 4};
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = 32'h0;
  logic        freeze = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg8, seg4;
  logic       dp8, dp4, fs8, fs4;
  logic [7:0] an8;
  logic [3:0] an4;

  sm_hex_display #(.DIGITS(8), .SCAN_DIV_W(SDW)) dut8 (
    .clk(clk), .rst(rst), .value(value), .freeze(freeze),
    .seg(seg8), .dp(dp8), .an(an8), .frame_start(fs8)
  );

  sm_hex_display #(.DIGITS(4), .SCAN_DIV_W(SDW)) dut4 (
    .clk(clk), .rst(rst), .value(value), .freeze(freeze),
    .seg(seg4), .dp(dp4), .an(an4), .frame_start(fs4)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in the scan follows from clocks elapsed since reset.
  int          m_cnt  [2];
  logic [31:0] m_snap [2];
  logic [6:0]  e_seg  [2];
  logic [7:0]  e_an   [2];
  logic        e_dp   [2];
  logic        e_fs   [2];

  always @(posedge clk) begin
    int slot, top, frame;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k]  = 0;
        m_snap[k] = 32'h0;
        e_seg[k]  = 7'h7F;
        e_an[k]   = 8'hFF;
        e_dp[k]   = 1'b1;
        e_fs[k]   = 1'b0;
      end else begin
        frame = P * DIG[k];
        slot  = (m_cnt[k] / P) % DIG[k];
        top   = 0;
        for (int j = 0; j < DIG[k]; j++) begin
          if (((m_snap[k] >> (4*j)) & 32'hF) != 0) top = j;
        end
        e_seg[k] = SEG_TAB[int'((m_snap[k] >> (4*slot)) & 32'hF)];
        e_an[k]  = 8'hFF;
`ifdef SM_DISPLAY_BLANK_EN
        if (slot <= top) e_an[k][slot] = 1'b0;
`else
        e_an[k][slot] = 1'b0;
`endif
        e_dp[k] = !(slot == 0 && freeze);
        e_fs[k] = (m_cnt[k] % frame) == frame - 1;
        if (e_fs[k] && !freeze) m_snap[k] = value;
        m_cnt[k]++;
      end
    end
  end

  // scoreboard compare, every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      check("seg8", 32'(seg8), 32'(e_seg[0]));
      check("an8",  32'(an8),  32'(e_an[0]));
      check("dp8",  32'(dp8),  32'(e_dp[0]));
      check("fs8",  32'(fs8),  32'(e_fs[0]));
      check("seg4", 32'(seg4), 32'(e_seg[1]));
      check("an4",  32'(an4),  32'(e_an[1][3:0]));
      check("dp4",  32'(dp4),  32'(e_dp[1]));
      check("fs4",  32'(fs4),  32'(e_fs[1]));
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(input bit four);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((four ? fs4 : fs8) === 1'b1) break;
    end
    if (i == 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL fs_timeout: got none want frame_start within 200 clocks");
    end
  endtask

  logic [6:0] exp2 [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [3:0] exp6_an [4];

  initial begin
    // reset held 3 clocks
    step(3);
    check("rst_an",  32'(an8),  32'hFF);
    check("rst_seg", 32'(seg8), 32'h7F);
    check("rst_dp",  32'(dp8),  32'h1);
    check("rst_fs",  32'(fs8),  32'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    step(1);
    check("first_an",  32'(an8),  32'hFE);
    check("first_seg", 32'(seg8), 32'h40);

    // normal scan of 1234ABCD
    value = 32'h1234ABCD;
    wait_fs(1'b0);
    step(1);
    for (int d = 0; d < 8; d++) begin
      if (d > 0) step(4);
      check("scan_an",  32'(an8),  32'(8'hFF ^ (8'h01 << d)));
      check("scan_seg", 32'(seg8), 32'(exp2[d]));
    end

    // freeze holds the snapshot across a load point
    wait_fs(1'b0);
    freeze = 1'b1;
    value  = 32'hFFFFFFFF;
    wait_fs(1'b0);
    step(1);
    check("frz_seg0", 32'(seg8), 32'h21);
    check("frz_an0",  32'(an8),  32'hFE);
    check("frz_dp0",  32'(dp8),  32'h0);
    step(4);
    check("frz_seg1", 32'(seg8), 32'h46);
    check("frz_dp1",  32'(dp8),  32'h1);
    freeze = 1'b0;
    wait_fs(1'b0);
    step(1);
    for (int d = 0; d < 8; d++) begin
      if (d > 0) step(4);
      check("unfrz_seg", 32'(seg8), 32'h0E);
    end

    // one-clock reset in the middle of a frame
    wait_fs(1'b0);
    step(1 + 5*4);
    rst = 1'b1;
    step(1);
    check("mrst_an",  32'(an8),  32'hFF);
    check("mrst_seg", 32'(seg8), 32'h7F);
    check("mrst_dp",  32'(dp8),  32'h1);
    check("mrst_fs",  32'(fs8),  32'h0);
    rst = 1'b0;
    step(1);
    check("mrst_an1",  32'(an8),  32'hFE);
    check("mrst_seg1", 32'(seg8), 32'h40);

`ifdef SM_DISPLAY_BLANK_EN
    value = 32'h000000A5;
    wait_fs(1'b0);
    step(1);
    check("blk_an0",  32'(an8),  32'hFE);
    check("blk_seg0", 32'(seg8), 32'h12);
    step(4);
    check("blk_an1",  32'(an8),  32'hFD);
    check("blk_seg1", 32'(seg8), 32'h08);
    step(4);
    check("blk_an2",  32'(an8),  32'hFF);
    value = 32'h0;
    wait_fs(1'b0);
    step(1);
    check("blk0_an0",  32'(an8),  32'hFE);
    check("blk0_seg0", 32'(seg8), 32'h40);
    step(4);
    check("blk0_an1",  32'(an8),  32'hFF);
    exp6_an = '{4'hE, 4'hF, 4'hF, 4'hF};
`else
    exp6_an = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif

    // 4-digit instance wraps from digit 3 to digit 0
    value = 32'hDEAD0007;
    wait_fs(1'b1);
    wait_fs(1'b1);
    step(1);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) step(4);
      check("d4_an",  32'(an4),  32'(exp6_an[d]));
      check("d4_seg", 32'(seg4), (d == 0) ? 32'h78 : 32'h40);
    end
    step(4);
    check("d4_wrap_an", 32'(an4), 32'hE);

    step(8);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
